// File: rtl/tt_logic_tester_if.sv
`default_nettype none
// ============================================================================
//  Module      : tt_logic_tester_if
//  Description : Pin bundle for the logic tester. io_in carries clock, reset,
//                start, gate response, settle and loop; io_out carries the
//                stimulus vector and the tester status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tt_logic_tester_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    // Side that drives the pins (board / bench)
    modport master (output io_in, input io_out);
    // Side that implements the tester
    modport slave  (input io_in, output io_out);
endinterface : tt_logic_tester_if
`default_nettype wire

// File: rtl/tt_logic_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tt_logic_tester
//  Description : Exhaustive tester for the 3-input gate y = a | (b & c).
//                Sweeps vec 0..7, holds each vector settle+1 cycles, samples
//                the gate response on the last hold cycle and keeps a
//                saturating 2-bit error count. Clock and active-low
//                synchronous reset arrive on io_in[0] and io_in[1].
//                Optional build macro TT_TESTER_LOOP_EN: io_in[6] makes the
//                tester re-run the sweep continuously from DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_logic_tester (
    input  wire  [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Pin breakout
    logic       clk;
    logic       rst_n;
    logic       w_start;
    logic       w_resp;
    logic [1:0] w_settle;
    logic       w_loop;

    assign clk      = io_in[0];
    assign rst_n    = io_in[1];
    assign w_start  = io_in[2];
    assign w_resp   = io_in[3];
    assign w_settle = io_in[5:4];
    assign w_loop   = io_in[6];

    state_t     r_state;
    logic       r_start_q;
    logic       r_armed;
    logic [1:0] r_settle;
    logic [1:0] r_hold;
    logic [2:0] r_vec;
    logic [1:0] r_err;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic       w_start_edge;
    logic       w_restart;
    logic       w_launch;
    logic       w_exp;
    logic       w_mismatch;
    logic [1:0] w_err_next;
    logic       w_last_hold;

    // r_armed blocks a start level that was already high across reset release
    assign w_start_edge = w_start & ~r_start_q & r_armed;

`ifdef TT_TESTER_LOOP_EN
    assign w_restart = w_start_edge | w_loop;
    logic w_unused_ok;
    assign w_unused_ok = io_in[7];
`else
    assign w_restart = w_start_edge;
    logic w_unused_ok;
    assign w_unused_ok = &{io_in[7], w_loop};
`endif

    // A new sweep starts from IDLE on a start edge, or from DONE on a restart
    assign w_launch = ((r_state == ST_IDLE) && w_start_edge) ||
                      ((r_state == ST_DONE) && w_restart);

    // Reference gate and saturating error update for the current vector
    assign w_exp       = r_vec[0] | (r_vec[1] & r_vec[2]);
    assign w_mismatch  = (w_resp != w_exp);
    assign w_err_next  = (w_mismatch && (r_err != 2'd3)) ? (r_err + 2'd1) : r_err;
    assign w_last_hold = (r_hold == r_settle);

    // Start level history and re-arm tracking for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_armed   <= ~w_start;
        end else begin
            r_start_q <= w_start;
            if (!w_start) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Sweep controller: state, stimulus vector, hold timer, error count, flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_settle <= 2'd0;
            r_hold   <= 2'd0;
            r_vec    <= 3'd0;
            r_err    <= 2'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else if (w_launch) begin
            r_state  <= ST_RUN;
            r_settle <= w_settle;
            r_hold   <= 2'd0;
            r_vec    <= 3'd0;
            r_err    <= 2'd0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_pass <= 1'b0;
                end
                ST_RUN: begin
                    if (w_last_hold) begin
                        r_err <= w_err_next;
                        if (r_vec == 3'd7) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 2'd0);
                        end else begin
                            r_vec  <= r_vec + 3'd1;
                            r_hold <= 2'd0;
                        end
                    end else begin
                        r_hold <= r_hold + 2'd1;
                    end
                end
                ST_DONE: begin
                    // vec, err_cnt and pass hold until restart or reset
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign io_out = {r_err, r_pass, r_done, r_busy, r_vec};

endmodule : tt_logic_tester
`default_nettype wire

// File: tb/tb_tt_logic_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_logic_tester
//  Description : Directed self-checking bench for tt_logic_tester. Drives the
//                pin bundle, models the gate under test (ideal or stuck-at-0)
//                and compares the whole io_out word every cycle of each sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_logic_tester;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       resp;
    logic [1:0] settle;
    logic       loop;
    int         gate_mode;   // 0 = ideal gate, 1 = output stuck at 0

    int n_checks;
    int n_errors;

    tt_logic_tester_if bus ();

    assign bus.io_in = {1'b0, loop, settle, resp, start, rst_n, clk};

    tt_logic_tester u_dut (
        .io_in  (bus.io_in),
        .io_out (bus.io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic gate_fn(input logic [2:0] v);
        return v[0] | (v[1] & v[2]);
    endfunction

    function automatic logic [7:0] pack(input int err, input bit pass, input bit done,
                                        input bit busy, input int vec);
        logic [1:0] e;
        logic [2:0] v;
        e = err[1:0];
        v = vec[2:0];
        return {e, pass, done, busy, v};
    endfunction

    // Advance one clock; the gate model then reacts to the new vector
    task automatic tick();
        @(posedge clk);
        #1;
        resp = (gate_mode == 0) ? gate_fn(bus.io_out[2:0]) : 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expects to be called with the DUT showing vec=0 in RUN; checks every
    // cycle of the sweep and the DONE word that follows.
    task automatic sweep(input int s, input string tag, input bit disturb);
        int err;
        int idx;
        err = 0;
        idx = 0;
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h <= s; h++) begin
                check({tag, "_run"}, {24'd0, bus.io_out}, {24'd0, pack(err, 1'b0, 1'b0, 1'b1, v)});
                if (disturb) begin
                    if (idx == 5)  settle = 2'd0;
                    if (idx == 9)  start  = 1'b1;
                    if (idx == 12) start  = 1'b0;
                end
                if ((h == s) && (resp != gate_fn(v[2:0])) && (err < 3)) err++;
                idx++;
                tick();
            end
        end
        check({tag, "_done"}, {24'd0, bus.io_out}, {24'd0, pack(err, (err == 0), 1'b1, 1'b0, 7)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        resp      = 1'b0;
        settle    = 2'd0;
        loop      = 1'b0;
        gate_mode = 0;

        // Reset state and idle after release
        repeat (3) tick();
        check("reset", {24'd0, bus.io_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle", {24'd0, bus.io_out}, 32'd0);

        // Ideal gate, settle 0; start kept high to show no retrigger
        start = 1'b1;
        tick();
        sweep(0, "ideal", 1'b0);
        repeat (3) tick();
        check("hold_high", {24'd0, bus.io_out}, {24'd0, pack(0, 1'b1, 1'b1, 1'b0, 7)});
        start = 1'b0;
        tick();

        // Gate stuck at 0: error count saturates, restart directly from DONE
        gate_mode = 1;
        resp      = 1'b0;
        start_pulse();
        sweep(0, "tie0", 1'b0);

        // Settle 3 with mid-run settle change and start edge, both ignored
        gate_mode = 0;
        settle    = 2'd3;
        start_pulse();
        sweep(3, "s3", 1'b1);

`ifdef TT_TESTER_LOOP_EN
        loop = 1'b1;
        tick();
        sweep(0, "loop1", 1'b0);
        tick();
        loop = 1'b0;
        sweep(0, "loop2", 1'b0);
        repeat (3) tick();
        check("loop_stop", {24'd0, bus.io_out}, {24'd0, pack(0, 1'b1, 1'b1, 1'b0, 7)});
`else
        loop = 1'b1;
        repeat (3) tick();
        check("loop_off", {24'd0, bus.io_out}, {24'd0, pack(0, 1'b1, 1'b1, 1'b0, 7)});
        loop = 1'b0;
`endif

        // Reset mid-run on vec=4, start held high across reset release
        settle = 2'd0;
        start_pulse();
        repeat (4) tick();
        check("pre_rst", {24'd0, bus.io_out}, {24'd0, pack(0, 1'b0, 1'b0, 1'b1, 4)});
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        check("mid_rst", {24'd0, bus.io_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_rerun", {24'd0, bus.io_out}, 32'd0);
        end
        start = 1'b0;
        tick();
        check("still_idle", {24'd0, bus.io_out}, 32'd0);
        start = 1'b1;
        tick();
        sweep(0, "post_rst", 1'b0);
        start = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tt_logic_tester
`default_nettype wire
